aes_round_sched: RTL and testbench
==================================

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

Interface
REQ-001 SHALL have parameter NR, default 10, meaning the number of AES rounds (legal range 2..14).
REQ-002 SHALL have parameter NCOL, default 4, meaning the number of columns sequenced through the shared column multiplier per round.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: begin one block encryption; sampled only in IDLE.
REQ-006 SHALL have port abort, input, 1 bit: cancel the operation in progress (see Configuration).
REQ-007 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the block completes.
REQ-009 SHALL have port round_cnt, output, 4 bits: current round, 0..NR.
REQ-010 SHALL have port sb_en, output, 1 bit: SubBytes strobe for the state register.
REQ-011 SHALL have port sr_en, output, 1 bit: ShiftRows strobe.
REQ-012 SHALL have port mc_en, output, 1 bit: column-multiplier write enable.
REQ-013 SHALL have port col_sel, output, 2 bits: column index for the column multiplier mux.
REQ-014 SHALL have port rk_req, output, 1 bit: round-key request.
REQ-015 SHALL have port rk_idx, output, 4 bits: index of the requested round key (equals round_cnt).
REQ-016 SHALL have port rk_ack, input, 1 bit: round key valid; handshake completes when rk_req and rk_ack are both high at a clock edge.
REQ-017 SHALL have port ark_en, output, 1 bit: AddRoundKey strobe, equal to rk_req AND rk_ack.

Function
REQ-018 SHALL implement the states IDLE, INIT_ARK, SUB, SHIFT, MIX, ARK and DONE.
REQ-019 In IDLE, start=1 SHALL move the FSM to INIT_ARK with round_cnt=0; start in any other state SHALL be ignored.
REQ-020 INIT_ARK and ARK SHALL hold rk_req=1 until rk_ack; the FSM SHALL wait indefinitely with all other strobes low.
REQ-021 On the INIT_ARK handshake, round_cnt SHALL become 1 and the FSM SHALL move to SUB.
REQ-022 SUB SHALL last 1 cycle with sb_en=1, then go to SHIFT; SHIFT SHALL last 1 cycle with sr_en=1.
REQ-023 From SHIFT the FSM SHALL go to MIX if round_cnt<NR, and to ARK if round_cnt=NR (the final round skips MixColumns).
REQ-024 MIX SHALL last exactly NCOL cycles with mc_en=1 and col_sel=0,1,..,NCOL-1 in consecutive cycles, then go to ARK.
REQ-025 col_sel SHALL be 0 whenever mc_en=0.
REQ-026 On the ARK handshake, if round_cnt<NR, round_cnt SHALL increment and the FSM SHALL go to SUB; otherwise it SHALL go to DONE.
REQ-027 DONE SHALL last 1 cycle with done=1 and busy=1, then go to IDLE; round_cnt SHALL hold NR until the next start.
REQ-028 With rk_ack tied high, NR=10 and NCOL=4, done SHALL be high exactly 68 cycles after the edge that samples start.
REQ-029 All outputs SHALL be registered or decoded only from state and counters, with no combinational path from start; ark_en is the one exception, allowed to depend on rk_ack.
REQ-030 At most one of sb_en, sr_en, mc_en and ark_en SHALL be high in any cycle.

Reset
REQ-031 rst=1 at a clock edge SHALL force IDLE, round_cnt=0 and col_sel=0, with busy, done, sb_en, sr_en, mc_en, rk_req and ark_en all 0.
REQ-032 Reset SHALL take priority over start, abort and rk_ack, including in the middle of an operation.

Configuration
REQ-033 With macro AES_SCHED_ABORT_EN defined, abort=1 in any non-IDLE state SHALL force IDLE at the next edge with round_cnt=0 and no done pulse; abort together with rk_ack SHALL favour abort.
REQ-034 Without AES_SCHED_ABORT_EN, the abort port SHALL still exist, be ignored, and synthesise to no logic.

Structure
REQ-035 The state encoding enum and the constants NR_DEFAULT and NCOL_DEFAULT SHALL live in the shared package aes_pkg.
REQ-036 The column counter SHALL be a sub-module aes_col_cnt with inputs clk, rst, en and outputs col_sel and last.

Verification
REQ-037 Bench SHALL drive reset with rst=1 for 2 cycles and check that all outputs are 0 and busy=0.
REQ-038 Bench SHALL drive start with rk_ack=1, NR=10 and check done at +68 cycles, 36 mc_en cycles in total, and no mc_en while round_cnt=10.
REQ-039 Bench SHALL drive rk_ack low for 5 cycles during the round-3 ARK and check that rk_req holds, rk_idx=3, the state is frozen, and done is delayed to +73.
REQ-040 Bench SHALL hold start high during busy and check that exactly one done occurs and there is no restart until IDLE.
REQ-041 Bench SHALL assert abort in the round-5 MIX at col_sel=2: with AES_SCHED_ABORT_EN, check IDLE next cycle and no done; without it, check done at +68.
REQ-042 Bench SHALL assert rst during the round-7 SUB and check IDLE and round_cnt=0 on the next cycle, then check that a fresh start completes normally.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared types and defaults for the AES round scheduler.
package aes_pkg;

    // Default number of AES rounds (AES-128).
    localparam int unsigned NR_DEFAULT   = 10;

    // Default number of state columns pushed through the shared column multiplier.
    localparam int unsigned NCOL_DEFAULT = 4;

    // Round scheduler states.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INIT_ARK = 3'd1,
        ST_SUB      = 3'd2,
        ST_SHIFT    = 3'd3,
        ST_MIX      = 3'd4,
        ST_ARK      = 3'd5,
        ST_DONE     = 3'd6
    } aes_state_e;

endpackage

// File: rtl/aes_col_cnt.sv
// aes_col_cnt: column index sequencer for the shared MixColumns multiplier.
// Counts 0..NCOL-1 while en is high and rests at 0 otherwise.
module aes_col_cnt #(
    parameter int unsigned NCOL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [1:0] col_sel,
    output logic       last
);

    localparam logic [1:0] LAST_COL = 2'(NCOL - 1);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    // Advance while enabled, wrapping to 0 after the last column.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == LAST_COL) ? '0 : cnt_q + 2'd1;
        end
    end

    // Column counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign col_sel = cnt_q;
    assign last    = (cnt_q == LAST_COL);

endmodule

// File: rtl/aes_round_sched.sv
// aes_round_sched: control FSM sequencing one AES block encryption:
// initial AddRoundKey, then NR rounds of SubBytes/ShiftRows/MixColumns/AddRoundKey
// (MixColumns skipped in the final round), with a round-key handshake.
// Optional feature: define AES_SCHED_ABORT_EN to make the abort input cancel
// an operation in progress; otherwise abort is ignored.
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int unsigned NR   = NR_DEFAULT,
    parameter int unsigned NCOL = NCOL_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       busy,
    output logic       done,
    output logic [3:0] round_cnt,
    output logic       sb_en,
    output logic       sr_en,
    output logic       mc_en,
    output logic [1:0] col_sel,
    output logic       rk_req,
    output logic [3:0] rk_idx,
    input  logic       rk_ack,
    output logic       ark_en
);

    localparam logic [3:0] NR_L = 4'(NR);

    aes_state_e state_q;
    logic [3:0] round_q;
    logic       busy_q;
    logic       done_q;
    logic       sb_q;
    logic       sr_q;
    logic       mc_q;
    logic       rk_req_q;

    logic       abort_hit;
    logic       col_clr;
    logic [1:0] col_q;
    logic       col_last;

`ifdef AES_SCHED_ABORT_EN
    assign abort_hit = abort && (state_q != ST_IDLE);
`else
    logic unused_abort;
    assign unused_abort = abort;
    assign abort_hit    = 1'b0;
`endif

    // An abort mid-MixColumns must leave the column counter back at 0.
    assign col_clr = rst || abort_hit;

    aes_col_cnt #(
        .NCOL (NCOL)
    ) u_col_cnt (
        .clk     (clk),
        .rst     (col_clr),
        .en      (mc_q),
        .col_sel (col_q),
        .last    (col_last)
    );

    // Scheduler FSM; strobes are registered for the state being entered.
    always_ff @(posedge clk) begin
        if (rst || abort_hit) begin
            state_q  <= ST_IDLE;
            round_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sb_q     <= 1'b0;
            sr_q     <= 1'b0;
            mc_q     <= 1'b0;
            rk_req_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            sb_q   <= 1'b0;
            sr_q   <= 1'b0;
            mc_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q   <= 1'b0;
                    rk_req_q <= 1'b0;
                    if (start) begin
                        state_q  <= ST_INIT_ARK;
                        round_q  <= '0;
                        busy_q   <= 1'b1;
                        rk_req_q <= 1'b1;
                    end
                end
                ST_INIT_ARK: begin
                    if (rk_ack) begin
                        state_q  <= ST_SUB;
                        round_q  <= 4'd1;
                        rk_req_q <= 1'b0;
                        sb_q     <= 1'b1;
                    end
                end
                ST_SUB: begin
                    state_q <= ST_SHIFT;
                    sr_q    <= 1'b1;
                end
                ST_SHIFT: begin
                    if (round_q < NR_L) begin
                        state_q <= ST_MIX;
                        mc_q    <= 1'b1;
                    end else begin
                        state_q  <= ST_ARK;
                        rk_req_q <= 1'b1;
                    end
                end
                ST_MIX: begin
                    if (col_last) begin
                        state_q  <= ST_ARK;
                        rk_req_q <= 1'b1;
                    end else begin
                        mc_q <= 1'b1;
                    end
                end
                ST_ARK: begin
                    if (rk_ack) begin
                        rk_req_q <= 1'b0;
                        if (round_q < NR_L) begin
                            state_q <= ST_SUB;
                            round_q <= round_q + 4'd1;
                            sb_q    <= 1'b1;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q  <= ST_IDLE;
                    round_q  <= '0;
                    busy_q   <= 1'b0;
                    rk_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign round_cnt = round_q;
    assign sb_en     = sb_q;
    assign sr_en     = sr_q;
    assign mc_en     = mc_q;
    assign col_sel   = mc_q ? col_q : '0;
    assign rk_req    = rk_req_q;
    assign rk_idx    = round_q;
    assign ark_en    = rk_req_q & rk_ack;

endmodule

// File: tb/tb_aes_round_sched.sv
// tb_aes_round_sched: self-checking bench for aes_round_sched.
// The reference model expands one block into a per-cycle list of expected
// output vectors (key fetch, then per round SUB, SHIFT, NCOL MIX columns,
// key fetch; then DONE), stretching key fetches over cycles with rk_ack low.
module tb_aes_round_sched;

    localparam int NR   = 10;
    localparam int NCOL = 4;
    localparam int MAXC = 512;

    // Field masks of the packed output vector.
    localparam logic [16:0] F_BUSY = 17'h10000;
    localparam logic [16:0] F_RND  = 17'h07800;
    localparam logic [16:0] F_SB   = 17'h00400;
    localparam logic [16:0] F_MC   = 17'h00100;
    localparam logic [16:0] F_COL  = 17'h000C0;
    localparam logic [16:0] F_REQ  = 17'h00020;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       rk_ack;
    logic       busy;
    logic       done;
    logic [3:0] round_cnt;
    logic       sb_en;
    logic       sr_en;
    logic       mc_en;
    logic [1:0] col_sel;
    logic       rk_req;
    logic [3:0] rk_idx;
    logic       ark_en;

    aes_round_sched #(
        .NR   (NR),
        .NCOL (NCOL)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .round_cnt (round_cnt),
        .sb_en     (sb_en),
        .sr_en     (sr_en),
        .mc_en     (mc_en),
        .col_sel   (col_sel),
        .rk_req    (rk_req),
        .rk_idx    (rk_idx),
        .rk_ack    (rk_ack),
        .ark_en    (ark_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit          ack_pat [MAXC];
    logic [16:0] exp_q [$];
    logic [16:0] obs_q [$];
    int          done_cyc;
    int          done_cnt;
    int          mc_cnt;
    int          mc_final_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Packed expected vector: {busy,done,round,sb,sr,mc,col,rk_req,rk_idx,ark_en}.
    function automatic logic [16:0] ent(input int b, d, r, sb, sr, mc, c, req, ark);
        return {1'(b), 1'(d), 4'(r), 1'(sb), 1'(sr), 1'(mc), 2'(c), 1'(req), 4'(r), 1'(ark)};
    endfunction

    function automatic bit ack_at(input int n);
        return (n >= MAXC) ? 1'b1 : ack_pat[n];
    endfunction

    // Key request for round r: waits while rk_ack is low, then one handshake cycle.
    task automatic push_key(input int r);
        while (!ack_at(exp_q.size() + 1)) exp_q.push_back(ent(1, 0, r, 0, 0, 0, 0, 1, 0));
        exp_q.push_back(ent(1, 0, r, 0, 0, 0, 0, 1, 1));
    endtask

    // Expected trace, entry i = cycle i+1 after the start edge. cut>0 means the
    // block is cancelled at that cycle and the FSM is idle from the next one.
    task automatic build_trace(input int cut);
        exp_q.delete();
        push_key(0);
        for (int r = 1; r <= NR; r++) begin
            exp_q.push_back(ent(1, 0, r, 1, 0, 0, 0, 0, 0));
            exp_q.push_back(ent(1, 0, r, 0, 1, 0, 0, 0, 0));
            if (r < NR) begin
                for (int c = 0; c < NCOL; c++) exp_q.push_back(ent(1, 0, r, 0, 0, 1, c, 0, 0));
            end
            push_key(r);
        end
        exp_q.push_back(ent(1, 1, NR, 0, 0, 0, 0, 0, 0));
        repeat (2) exp_q.push_back(ent(0, 0, NR, 0, 0, 0, 0, 0, 0));
        if (cut > 0) begin
            while (exp_q.size() > cut) void'(exp_q.pop_back());
            repeat (2) exp_q.push_back(ent(0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    function automatic int find_cyc(input logic [16:0] mask, input logic [16:0] val);
        for (int i = 0; i < exp_q.size(); i++) begin
            if ((exp_q[i] & mask) == (val & mask)) return i + 1;
        end
        return 0;
    endfunction

    // Runs one block against the current expected trace.
    task automatic run_block(input int abort_cyc, input int rst_cyc, input bit hold);
        int          idle_n;
        logic [16:0] obs;
        idle_n = exp_q.size() + 1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i][16] == 1'b0) begin
                idle_n = i + 1;
                break;
            end
        end
        obs_q.delete();
        done_cyc     = -1;
        done_cnt     = 0;
        mc_cnt       = 0;
        mc_final_cnt = 0;
        @(negedge clk);
        start  = 1'b1;
        rst    = 1'b0;
        abort  = 1'b0;
        rk_ack = 1'b1;
        for (int n = 1; n <= exp_q.size(); n++) begin
            @(negedge clk);
            rk_ack = ack_at(n);
            abort  = (n == abort_cyc);
            rst    = (n == rst_cyc);
            start  = hold && (n < idle_n);
            #1;
            obs = {busy, done, round_cnt, sb_en, sr_en, mc_en, col_sel, rk_req, rk_idx, ark_en};
            obs_q.push_back(obs);
            check_eq($sformatf("trace@%0d", n), 32'(obs), 32'(exp_q[n-1]));
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (mc_en) begin
                mc_cnt++;
                if (round_cnt == 4'(NR)) mc_final_cnt++;
            end
        end
        @(negedge clk);
        start  = 1'b0;
        abort  = 1'b0;
        rst    = 1'b0;
        rk_ack = 1'b1;
    endtask

    task automatic all_ack();
        for (int i = 0; i < MAXC; i++) ack_pat[i] = 1'b1;
    endtask

    initial begin
        int k3, a5, c7, exp_done;
        bit hold;

        rst    = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        rk_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("reset_outputs",
                 32'({busy, done, round_cnt, sb_en, sr_en, mc_en, col_sel, rk_req, rk_idx, ark_en}), 32'd0);
        check_eq("reset_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Nominal block, key always ready.
        all_ack();
        build_trace(0);
        k3 = find_cyc(F_RND | F_REQ, ent(1, 0, 3, 0, 0, 0, 0, 1, 0));
        a5 = find_cyc(F_RND | F_MC | F_COL, ent(1, 0, 5, 0, 0, 1, 2, 0, 0));
        c7 = find_cyc(F_RND | F_SB, ent(1, 0, 7, 1, 0, 0, 0, 0, 0));
        run_block(0, 0, 1'b0);
        check_eq("nominal_done_latency", 32'(done_cyc), 32'd68);
        check_eq("nominal_done_count", 32'(done_cnt), 32'd1);
        check_eq("nominal_mc_cycles", 32'(mc_cnt), 32'd36);
        check_eq("nominal_mc_final_round", 32'(mc_final_cnt), 32'd0);

        // Round-key stall of 5 cycles in the round-3 key fetch.
        for (int i = k3; i < k3 + 5; i++) ack_pat[i] = 1'b0;
        build_trace(0);
        run_block(0, 0, 1'b0);
        for (int i = k3; i < k3 + 5; i++) begin
            check_eq($sformatf("stall_hold@%0d", i), 32'(obs_q[i-1]), 32'(ent(1, 0, 3, 0, 0, 0, 0, 1, 0)));
        end
        check_eq("stall_done_latency", 32'(done_cyc), 32'd73);
        all_ack();

        // start held high for the whole block.
        build_trace(0);
        run_block(0, 0, 1'b1);
        check_eq("held_start_done_count", 32'(done_cnt), 32'd1);
        check_eq("held_start_done_latency", 32'(done_cyc), 32'd68);

        // abort in round-5 MixColumns at column 2.
`ifdef AES_SCHED_ABORT_EN
        build_trace(a5);
        run_block(a5, 0, 1'b0);
        check_eq("abort_done_count", 32'(done_cnt), 32'd0);
        check_eq("abort_idle_busy", 32'(obs_q[a5][16]), 32'd0);
        check_eq("abort_idle_round", 32'(obs_q[a5][14:11]), 32'd0);
`else
        build_trace(0);
        run_block(a5, 0, 1'b0);
        check_eq("abort_ignored_done_latency", 32'(done_cyc), 32'd68);
        check_eq("abort_ignored_done_count", 32'(done_cnt), 32'd1);
`endif

        // Reset during round-7 SubBytes, then a fresh block.
        build_trace(c7);
        run_block(0, c7, 1'b0);
        check_eq("midrst_busy", 32'(obs_q[c7][16]), 32'd0);
        check_eq("midrst_round", 32'(obs_q[c7][14:11]), 32'd0);
        check_eq("midrst_done_count", 32'(done_cnt), 32'd0);
        build_trace(0);
        run_block(0, 0, 1'b0);
        check_eq("after_rst_done_latency", 32'(done_cyc), 32'd68);

        // Random key-ready patterns and start holding.
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < MAXC; i++) ack_pat[i] = ($urandom_range(0, 3) != 0);
            hold = 1'($urandom_range(0, 1));
            build_trace(0);
            exp_done = find_cyc(17'h08000, 17'h08000);
            run_block(0, 0, hold);
            check_eq($sformatf("rand%0d_done_latency", it), 32'(done_cyc), 32'(exp_done));
            check_eq($sformatf("rand%0d_done_count", it), 32'(done_cnt), 32'd1);
            check_eq($sformatf("rand%0d_mc_cycles", it), 32'(mc_cnt), 32'(NCOL * (NR - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
